// File: rtl/fwd_ctrl_unit.sv
// rtl/fwd_ctrl_unit.sv - operand forwarding select and load-use stall controller
// Optional feature macro: FWD_STALL_CNT_EN (adds out_stall_cnt, saturating stall-cycle counter)
module fwd_ctrl_unit #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic              in_flush,
  output logic [1:0]        out_cntrl_m2,
  output logic [1:0]        out_cntrl_m3,
`ifdef FWD_STALL_CNT_EN
  output logic [15:0]       out_stall_cnt,
`endif
  output logic              out_stall
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b11;

  logic              ex_v;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wr;
  logic              ex_ld;
  logic              mem_v;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wr;

  logic [1:0]        sel_rs1;
  logic [1:0]        sel_rs2;
  logic              ex_hit_rs1;
  logic              ex_hit_rs2;
  logic              mem_hit_rs1;
  logic              mem_hit_rs2;

  // Producer matches: the EX-stage producer is the newest and wins over MEM
  always_comb begin
    ex_hit_rs1  = ex_v & ex_wr & (in_rs1 == ex_rd);
    ex_hit_rs2  = ex_v & ex_wr & (in_rs2 == ex_rd);
    mem_hit_rs1 = mem_v & mem_wr & (in_rs1 == mem_rd);
    mem_hit_rs2 = mem_v & mem_wr & (in_rs2 == mem_rd);
    sel_rs1 = SEL_NONE;
    sel_rs2 = SEL_NONE;
    if (ex_hit_rs1)       sel_rs1 = SEL_EXM;
    else if (mem_hit_rs1) sel_rs1 = SEL_WB;
    if (ex_hit_rs2)       sel_rs2 = SEL_EXM;
    else if (mem_hit_rs2) sel_rs2 = SEL_WB;
  end

  // A load in EX cannot feed its data to the ID instruction in time; flush cancels the hazard
  assign out_stall = in_valid & ex_v & ex_wr & ex_ld &
                     ((in_rs1 == ex_rd) | (in_rs2 == ex_rd)) & ~in_flush;

  // Pipeline tracking and registered mux selects for the instruction entering EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v         <= 1'b0;
      ex_rd        <= '0;
      ex_wr        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_v        <= 1'b0;
      mem_rd       <= '0;
      mem_wr       <= 1'b0;
      out_cntrl_m2 <= SEL_NONE;
      out_cntrl_m3 <= SEL_NONE;
    end else if (in_flush) begin
      ex_v         <= 1'b0;
      mem_v        <= 1'b0;
      out_cntrl_m2 <= SEL_NONE;
      out_cntrl_m3 <= SEL_NONE;
    end else if (out_stall) begin
      ex_v         <= 1'b0;
      mem_v        <= ex_v;
      mem_rd       <= ex_rd;
      mem_wr       <= ex_wr;
      out_cntrl_m2 <= SEL_NONE;
      out_cntrl_m3 <= SEL_NONE;
    end else begin
      ex_v         <= in_valid;
      ex_rd        <= in_rd;
      ex_wr        <= in_wr_en;
      ex_ld        <= in_is_load;
      mem_v        <= ex_v;
      mem_rd       <= ex_rd;
      mem_wr       <= ex_wr;
      out_cntrl_m2 <= sel_rs1;
      out_cntrl_m3 <= sel_rs2;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_stall_cnt <= 16'h0000;
    end else if (out_stall && (out_stall_cnt != 16'hFFFF)) begin
      out_stall_cnt <= out_stall_cnt + 16'h0001;
    end
  end
`endif

endmodule
